// File: rtl/range_mapper.sv
`default_nettype none
// ============================================================================
//  Module   : range_mapper
//  Purpose  : Maps a raw WIDTH-bit value (typically an LFSR sample) into the
//             inclusive range [min,max], either by modulo or by proportional
//             scaling. Iterative shift-subtract / shift-add datapath: one bit
//             per cycle, no divider and no multiplier. Valid/ready on both
//             sides, one request in flight at a time.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1      rising-edge clock
//    resetn     in   1      synchronous, active-low reset
//    in_valid   in   1      request present on num/min/max/mode
//    in_ready   out  1      block can accept a request (IDLE only)
//    num        in   WIDTH  raw value to map
//    min        in   WIDTH  inclusive lower bound
//    max        in   WIDTH  inclusive upper bound
//    mode       in   1      0 = modulo, 1 = scale
//    out_valid  out  1      result/err valid, held until out_ready
//    out_ready  in   1      consumer accepts result
//    result     out  WIDTH  mapped value (= min on err)
//    err        out  1      request had max < min
// ============================================================================
module range_mapper #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] min,
  input  logic [WIDTH-1:0] max,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic             w_accept;
  logic             w_last;

  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_num;   // shift register feeding one bit per cycle
  logic [WIDTH-1:0]     r_min;
  logic [WIDTH:0]       r_span;
  logic                 r_mode;
  logic                 r_bad;
  logic [WIDTH-1:0]     r_rem;   // partial remainder, always < span
  logic [2*WIDTH:0]     r_acc;   // shift-add accumulator

  logic [WIDTH:0]       w_span;
  logic [WIDTH:0]       w_shift;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_rem_next;
  logic [2*WIDTH:0]     w_addend;
  logic [2*WIDTH:0]     w_acc_next;
  logic [WIDTH-1:0]     w_q;

  // span is one bit wider than the operands so the full range 2^WIDTH fits.
  assign w_span = {1'b0, max} - {1'b0, min} + (WIDTH + 1)'(1);

  assign w_last = (r_cnt == CW'(WIDTH));

  // Modulo: restoring division, quotient bits discarded, MSB of num first.
  // 2*rem+bit < 2*span <= 2^(WIDTH+1), so WIDTH+1 bits hold the trial value.
  assign w_shift    = {r_rem, r_num[WIDTH-1]};
  assign w_ge       = (w_shift >= r_span);
  assign w_rem_next = WIDTH'(w_ge ? (w_shift - r_span) : w_shift);

  // Scale: LSB of num first, add span aligned to the top half and halve.
  // After WIDTH steps the accumulator holds num*span exactly; the sum before
  // halving stays below 2*span*2^WIDTH, which fits 2*WIDTH+1 bits.
  assign w_addend   = r_num[0] ? {r_span, {WIDTH{1'b0}}} : '0;
  assign w_acc_next = (r_acc + w_addend) >> 1;

  // Both candidates are strictly below span, so min + w_q never exceeds max.
  assign w_q = r_mode ? r_acc[2*WIDTH-1:WIDTH] : r_rem;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_accept  = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = S_CALC;
        end
      end
      S_CALC: begin
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt  <= '0;
      r_num  <= '0;
      r_min  <= '0;
      r_span <= '0;
      r_mode <= 1'b0;
      r_bad  <= 1'b0;
      r_rem  <= '0;
      r_acc  <= '0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt  <= '0;
        r_num  <= num;
        r_min  <= min;
        r_span <= w_span;
        r_mode <= mode;
        r_bad  <= (max < min);
        r_rem  <= '0;
        r_acc  <= '0;
      end else if (r_state == S_CALC) begin
        if (w_last) begin
          // An invalid range still runs the full iteration count so the
          // latency seen by the consumer never depends on the operands.
          result <= r_bad ? r_min : (r_min + w_q);
          err    <= r_bad;
        end else begin
          r_cnt <= r_cnt + CW'(1);
          if (r_mode) begin
            r_acc <= w_acc_next;
            r_num <= r_num >> 1;
          end else begin
            r_rem <= w_rem_next;
            r_num <= r_num << 1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_range_mapper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_range_mapper
//  Purpose  : Self-checking bench for range_mapper (WIDTH=16): directed
//             boundary cases followed by randomized requests, all compared
//             against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_range_mapper;

  localparam int WIDTH = 16;

  logic             clk;
  logic             resetn;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] num;
  logic [WIDTH-1:0] min;
  logic [WIDTH-1:0] max;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             err;

  int n_vec;
  int n_bad;

  range_mapper #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num       (num),
    .min       (min),
    .max       (max),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {err, result} from plain integer arithmetic.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] lo,
                                           input logic [WIDTH-1:0] hi, input logic m);
    longint span;
    longint r;
    if (hi < lo) return {1'b1, lo};
    span = longint'(hi) - longint'(lo) + 1;
    if (m) r = longint'(lo) + ((longint'(n) * span) >> WIDTH);
    else   r = longint'(lo) + (longint'(n) % span);
    return {1'b0, r[WIDTH-1:0]};
  endfunction

  // Issues one request and completes it. Caller is at a negedge in IDLE.
  // hold = number of cycles out_ready stays low once out_valid is up.
  task automatic run_req(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] lo,
                         input logic [WIDTH-1:0] hi, input logic m, input int hold);
    logic [WIDTH:0] exp;
    int lat;
    exp = model(n, lo, hi, m);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    num = n; min = lo; max = hi; mode = m; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);                       // accepting edge
    @(negedge clk);
    in_valid = 1'b0;
    num = WIDTH'($urandom); min = WIDTH'($urandom); max = WIDTH'($urandom); mode = ~m;
    check("in_ready_busy", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("latency", 32'(lat), 32'(WIDTH + 1));
    check("result", 32'(result), 32'(exp[WIDTH-1:0]));
    check("err", 32'(err), 32'(exp[WIDTH]));
    for (int i = 0; i < hold; i++) begin
      in_valid = ~in_valid;
      num = WIDTH'($urandom);
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_result", 32'(result), 32'(exp[WIDTH-1:0]));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [WIDTH-1:0] lo, hi;
    int sel;
    n_vec = 0; n_bad = 0;
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    num = '0; min = '0; max = '0; mode = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed cases
    run_req(16'd1000, 16'd5, 16'd14, 1'b0, 1);
    run_req(16'h8000, 16'd0, 16'd99, 1'b1, 0);
    run_req(16'hFFFF, 16'd0, 16'd99, 1'b1, 0);
    run_req(16'hBEEF, 16'd0, 16'hFFFF, 1'b0, 0);
    run_req(16'hBEEF, 16'd0, 16'hFFFF, 1'b1, 2);
    run_req(16'h1234, 16'd20, 16'd10, 1'b0, 0);
    run_req(16'h1234, 16'd20, 16'd10, 1'b1, 0);
    run_req(16'hA5A5, 16'd77, 16'd77, 1'b0, 0);
    run_req(16'hA5A5, 16'd77, 16'd77, 1'b1, 0);
    run_req(16'h4321, 16'd300, 16'd4000, 1'b0, 5);

    // Reset in the middle of CALC
    num = 16'd999; min = 16'd3; max = 16'd50; mode = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    repeat (20) begin
      @(negedge clk);
      check("abort_no_valid", 32'(out_valid), 32'd0);
    end
    run_req(16'd7, 16'd1, 16'd3, 1'b0, 0);

    // Randomized requests
    for (int k = 0; k < 60; k++) begin
      sel = int'($urandom_range(0, 5));
      lo  = WIDTH'($urandom);
      hi  = WIDTH'($urandom);
      if (sel == 0) hi = lo;
      else if (sel == 1) begin lo = '0; hi = '1; end
      else if (sel == 2) hi = lo + WIDTH'($urandom_range(0, 20));
      else if (sel == 3 && hi < lo) begin lo = lo ^ hi; hi = lo ^ hi; lo = lo ^ hi; end
      run_req(WIDTH'($urandom), lo, hi, 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
